hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline hazard controller: drives the 2-bit {stall,flush} mode inputs of IF_ID, ID_EX,
//  EX_MEM and MEM_WB, plus the PC-hold signal. Handles load-use bubbles, taken-branch
//  flushes, data-memory wait freezes and a multi-cycle MDU (mul/div) stall via an FSM.
//  Mode encoding: 2'b00 normal, 2'b01 flush (bit0), 2'b10 stall (bit1). 2'b11 is never driven.
// PARAMETERS
//  MDU_LATENCY  4  total stall cycles per MDU op, including the start cycle; legal range 1..15
//  REG_ADDR_W   5  register-index width
// PORTS
//  clk_i             in   1           clock; all state updates on posedge
//  rst_ni            in   1           asynchronous active-low reset
//  id_rs1_i          in   REG_ADDR_W  rs1 index of the instruction in ID
//  id_rs2_i          in   REG_ADDR_W  rs2 index of the instruction in ID
//  id_rs1_used_i     in   1           ID instruction reads rs1
//  id_rs2_used_i     in   1           ID instruction reads rs2
//  ex_rd_i           in   REG_ADDR_W  rd index of the instruction in EX
//  ex_mem_read_i     in   1           EX instruction is a load
//  ex_branch_taken_i in   1           EX resolved a taken branch or jump
//  ex_mdu_op_i       in   1           EX instruction is an MDU op
//  dmem_wait_i       in   1           data memory not ready; MEM must hold
//  pc_stall_o        out  1           hold PC
//  if_id_mode_o      out  2           IF_ID mode
//  id_ex_mode_o      out  2           ID_EX mode
//  ex_mem_mode_o     out  2           EX_MEM mode
//  mem_wb_mode_o     out  2           MEM_WB mode
// BEHAVIOUR
//  State: fsm in {RUN, MDU_WAIT}; cnt[3:0]; mdu_done (1 bit). Outputs are combinational
//  from state and inputs: same-cycle response, zero latency.
//  Reset (rst_ni=0, asynchronous): fsm=RUN, cnt=0, mdu_done=0; outputs forced to
//  pc_stall_o=1 and all four modes = 2'b01 (flush) while reset is held.
//  Output priority, highest first:
//   1 dmem_wait_i: pc_stall=1; IF_ID, ID_EX, EX_MEM = 10 (stall); MEM_WB = 01.
//     FSM, cnt and mdu_done hold their values.
//   2 mdu_stall = (fsm==MDU_WAIT) | (fsm==RUN & ex_mdu_op_i & ~mdu_done & MDU_LATENCY>1):
//     pc_stall=1; IF_ID, ID_EX = 10; EX_MEM = 01; MEM_WB = 00.
//   3 ex_branch_taken_i: pc_stall=0 (PC loads target); IF_ID, ID_EX = 01; others 00.
//     Taken branch outranks load-use because the dependent ID instruction is flushed.
//   4 load_use = ex_mem_read_i & ex_rd_i!=0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) |
//     (id_rs2_used_i & id_rs2_i==ex_rd_i)): pc_stall=1; IF_ID=10; ID_EX=01; others 00.
//     Lasts exactly 1 cycle, because the load leaves EX at the next edge.
//   5 otherwise: pc_stall=0; all modes 00.
//  FSM transitions, evaluated only when dmem_wait_i=0:
//   RUN: if ex_mdu_op_i & ~mdu_done & MDU_LATENCY>1, go to MDU_WAIT with cnt<=MDU_LATENCY-1.
//        mdu_done<=0 on every RUN edge.
//   MDU_WAIT: cnt<=cnt-1 each edge. When cnt==1, go to RUN with cnt<=0 and mdu_done<=1.
//  Total stall: MDU_LATENCY cycles, then one release cycle. In the release cycle the MDU op is
//  still in EX; mdu_done=1 blocks a restart. MDU_LATENCY==1: never stalls, FSM stays in RUN.
//  dmem_wait during MDU_WAIT: cnt freezes, so the MDU stall is extended by the wait length.
//  Reset during MDU_WAIT: returns immediately to RUN with cnt=0. After release, a still-present
//  ex_mdu_op_i is treated as a new op only if mdu_done=0.
//  ex_rd_i==0 never causes a load-use stall.
// TESTING
//  1 Reset held 3 cycles -> pc_stall=1, all modes 01; release with no hazard -> all 00, pc_stall=0.
//  2 ex_mem_read=1, ex_rd=5, id_rs2=5, rs2_used=1 for 1 cycle -> pc_stall=1, IF_ID=10, ID_EX=01
//    that cycle; ex_rd=0 with the same sources -> no stall.
//  3 MDU_LATENCY=4, ex_mdu_op held 5 cycles -> cycles 0-3 IF_ID=ID_EX=10, EX_MEM=01;
//    cycle 4 all 00, no restart.
//  4 Taken branch together with load-use -> IF_ID=ID_EX=01, pc_stall=0.
//  5 dmem_wait=1 for 2 cycles inside MDU_WAIT with cnt=2 -> MEM_WB=01, cnt holds;
//    stall extended to 6 cycles total.
//  6 rst_ni pulsed low mid-MDU_WAIT -> outputs go to reset values asynchronously; after
//    release, with ex_mdu_op=1, a fresh 4-cycle stall runs.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard sources in, pipeline-register modes and PC hold out.
// The pipeline side drives the master modport; the hazard controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  ex_mem_read_i;
    logic                  ex_branch_taken_i;
    logic                  ex_mdu_op_i;
    logic                  dmem_wait_i;
    logic                  pc_stall_o;
    logic [1:0]            if_id_mode_o;
    logic [1:0]            id_ex_mode_o;
    logic [1:0]            ex_mem_mode_o;
    logic [1:0]            mem_wb_mode_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_mem_read_i, ex_branch_taken_i, ex_mdu_op_i, dmem_wait_i,
        input  pc_stall_o, if_id_mode_o, id_ex_mode_o, ex_mem_mode_o, mem_wb_mode_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_mem_read_i, ex_branch_taken_i, ex_mdu_op_i, dmem_wait_i,
        output pc_stall_o, if_id_mode_o, id_ex_mode_o, ex_mem_mode_o, mem_wb_mode_o
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, dmem-wait freezes and
// multi-cycle MDU stalls. Mode outputs are combinational (same-cycle response).
module hazard_ctrl_unit #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic       MDU_MULTI = (MDU_LATENCY > 1);

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FLUSH  = 2'b01;
    localparam logic [1:0] MODE_STALL  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } fsm_t;

    fsm_t             fsm, fsm_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             mdu_done, mdu_done_next;

    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  rs1_hit, rs2_hit;
    logic                  load_use, mdu_start, mdu_stall;

    assign rs1 = bus.id_rs1_i;
    assign rs2 = bus.id_rs2_i;
    assign rd  = bus.ex_rd_i;

    // Register x0 is hardwired to zero, so a load into it creates no dependency.
    assign rs1_hit  = bus.id_rs1_used_i && (rs1 == rd);
    assign rs2_hit  = bus.id_rs2_used_i && (rs2 == rd);
    assign load_use = bus.ex_mem_read_i && (rd != '0) && (rs1_hit || rs2_hit);

    // mdu_done suppresses a restart while the finished op still sits in EX.
    assign mdu_start = (fsm == RUN) && bus.ex_mdu_op_i && !mdu_done && MDU_MULTI;
    assign mdu_stall = (fsm == MDU_WAIT) || mdu_start;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm      <= RUN;
            cnt      <= '0;
            mdu_done <= 1'b0;
        end else begin
            fsm      <= fsm_next;
            cnt      <= cnt_next;
            mdu_done <= mdu_done_next;
        end
    end

    // Next-state: everything freezes while data memory is waiting.
    always_comb begin
        fsm_next      = fsm;
        cnt_next      = cnt;
        mdu_done_next = mdu_done;
        if (!bus.dmem_wait_i) begin
            case (fsm)
                RUN: begin
                    mdu_done_next = 1'b0;
                    if (mdu_start) begin
                        fsm_next = MDU_WAIT;
                        cnt_next = CNT_INIT;
                    end
                end
                MDU_WAIT: begin
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        fsm_next      = RUN;
                        cnt_next      = '0;
                        mdu_done_next = 1'b1;
                    end
                end
                default: begin
                    fsm_next = RUN;
                    cnt_next = '0;
                end
            endcase
        end
    end

    // Output priority: reset, dmem wait, MDU, taken branch, load-use.
    always_comb begin
        bus.pc_stall_o    = 1'b0;
        bus.if_id_mode_o  = MODE_NORMAL;
        bus.id_ex_mode_o  = MODE_NORMAL;
        bus.ex_mem_mode_o = MODE_NORMAL;
        bus.mem_wb_mode_o = MODE_NORMAL;
        if (!rst_ni) begin
            bus.pc_stall_o    = 1'b1;
            bus.if_id_mode_o  = MODE_FLUSH;
            bus.id_ex_mode_o  = MODE_FLUSH;
            bus.ex_mem_mode_o = MODE_FLUSH;
            bus.mem_wb_mode_o = MODE_FLUSH;
        end else if (bus.dmem_wait_i) begin
            bus.pc_stall_o    = 1'b1;
            bus.if_id_mode_o  = MODE_STALL;
            bus.id_ex_mode_o  = MODE_STALL;
            bus.ex_mem_mode_o = MODE_STALL;
            bus.mem_wb_mode_o = MODE_FLUSH;
        end else if (mdu_stall) begin
            bus.pc_stall_o    = 1'b1;
            bus.if_id_mode_o  = MODE_STALL;
            bus.id_ex_mode_o  = MODE_STALL;
            bus.ex_mem_mode_o = MODE_FLUSH;
        end else if (bus.ex_branch_taken_i) begin
            bus.if_id_mode_o  = MODE_FLUSH;
            bus.id_ex_mode_o  = MODE_FLUSH;
        end else if (load_use) begin
            bus.pc_stall_o    = 1'b1;
            bus.if_id_mode_o  = MODE_STALL;
            bus.id_ex_mode_o  = MODE_FLUSH;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: reset, load-use, branch priority, MDU stall,
// dmem-wait extension and asynchronous reset during an MDU stall.
module tb_hazard_ctrl_unit;
    // Expected {pc_stall, if_id, id_ex, ex_mem, mem_wb}
    localparam logic [8:0] E_NONE = 9'b0_00_00_00_00;
    localparam logic [8:0] E_RST  = 9'b1_01_01_01_01;
    localparam logic [8:0] E_LU   = 9'b1_10_01_00_00;
    localparam logic [8:0] E_MDU  = 9'b1_10_10_01_00;
    localparam logic [8:0] E_BR   = 9'b0_01_01_00_00;
    localparam logic [8:0] E_DMEM = 9'b1_10_10_10_01;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

    hazard_ctrl_unit #(.MDU_LATENCY(4), .REG_ADDR_W(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.pc_stall_o, bus.if_id_mode_o, bus.id_ex_mode_o,
               bus.ex_mem_mode_o, bus.mem_wb_mode_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = dut.cnt;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed cnt %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_rs1_i          = '0;
        bus.id_rs2_i          = '0;
        bus.id_rs1_used_i     = 1'b0;
        bus.id_rs2_used_i     = 1'b0;
        bus.ex_rd_i           = '0;
        bus.ex_mem_read_i     = 1'b0;
        bus.ex_branch_taken_i = 1'b0;
        bus.ex_mdu_op_i       = 1'b0;
        bus.dmem_wait_i       = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();

        // Reset held for three cycles, then released with no hazard
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 chk("reset_hold", E_RST);
        end
        chk_cnt("reset_cnt", 4'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("reset_release", E_NONE);

        // Load-use on rs2, then x0 destination, then rs1 with used gating
        @(negedge clk);
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd5;
        bus.id_rs2_i = 5'd5; bus.id_rs2_used_i = 1'b1;
        #1 chk("load_use_rs2", E_LU);
        @(negedge clk); bus.ex_rd_i = 5'd0; bus.id_rs2_i = 5'd0;
        #1 chk("load_use_x0", E_NONE);
        @(negedge clk); clear_inputs();
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd7;
        bus.id_rs1_i = 5'd7; bus.id_rs1_used_i = 1'b1; bus.id_rs2_i = 5'd3;
        #1 chk("load_use_rs1", E_LU);
        @(negedge clk); bus.id_rs1_used_i = 1'b0;
        #1 chk("load_use_rs1_unused", E_NONE);
        @(negedge clk); bus.id_rs1_used_i = 1'b1; bus.ex_mem_read_i = 1'b0;
        #1 chk("no_load_no_stall", E_NONE);

        // Taken branch outranks a simultaneous load-use
        @(negedge clk); bus.ex_mem_read_i = 1'b1; bus.ex_branch_taken_i = 1'b1;
        #1 chk("branch_over_load_use", E_BR);
        @(negedge clk); clear_inputs();
        #1 chk("idle_after_branch", E_NONE);

        // MDU op held five cycles: four stall cycles, release cycle without restart
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus.ex_mdu_op_i = 1'b1;
            #1 chk($sformatf("mdu_cycle%0d", i), (i < 4) ? E_MDU : E_NONE);
        end
        @(negedge clk); bus.ex_mdu_op_i = 1'b0;
        #1 chk("mdu_idle", E_NONE);

        // dmem wait for two cycles while cnt==2 stretches the stall to six cycles
        @(negedge clk); bus.ex_mdu_op_i = 1'b1;
        #1 chk("mdw_cycle0", E_MDU);
        @(negedge clk); #1 chk("mdw_cycle1", E_MDU);
        @(negedge clk); bus.dmem_wait_i = 1'b1;
        #1 chk("mdw_cycle2_wait", E_DMEM);
        chk_cnt("mdw_cnt_c2", 4'd2);
        @(negedge clk); #1 chk("mdw_cycle3_wait", E_DMEM);
        chk_cnt("mdw_cnt_c3", 4'd2);
        @(negedge clk); bus.dmem_wait_i = 1'b0;
        #1 chk("mdw_cycle4", E_MDU);
        chk_cnt("mdw_cnt_c4", 4'd2);
        @(negedge clk); #1 chk("mdw_cycle5", E_MDU);
        chk_cnt("mdw_cnt_c5", 4'd1);
        @(negedge clk); #1 chk("mdw_release", E_NONE);
        @(negedge clk); bus.ex_mdu_op_i = 1'b0;
        #1 chk("mdw_idle", E_NONE);

        // Asynchronous reset pulse mid-stall, then a fresh four-cycle stall
        @(negedge clk); bus.ex_mdu_op_i = 1'b1;
        #1 chk("rst_mdu_cycle0", E_MDU);
        @(negedge clk); #1 chk("rst_mdu_cycle1", E_MDU);
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk("rst_async_outputs", E_RST);
        chk_cnt("rst_async_cnt", 4'd0);
        #1 rst_n = 1'b1;
        #1 chk("fresh_cycle0", E_MDU);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            #1 chk($sformatf("fresh_cycle%0d", i), (i < 4) ? E_MDU : E_NONE);
        end
        @(negedge clk); clear_inputs();
        #1 chk("final_idle", E_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
